instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Parametrised fetch stage for the MIPS pipeline: holds a loadable instruction memory, a program counter with sequential, stalled and redirected update, and a registered IF/ID output with a valid bit. A small mode FSM separates program load, normal fetch and a fault halt. It sits between the test/boot loader and the decode stage, which consumes `if_*` and drives `stall`, `flush` and `redirect_*` back.

## Interface
- `ADDR_W`, 5: word-address bits; memory depth is 2^ADDR_W words of 32 bits.
- `RESET_PC`, 32'h0: PC value after reset; must be word aligned and inside memory.
- `NOP_WORD`, 32'h0: instruction word driven on bubbles and reset.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold PC and IF/ID register.
- `flush` in 1: kill the IF/ID contents next edge.
- `redirect_en` in 1: load PC from `redirect_pc`; implies flush.
- `redirect_pc` in 32: branch/jump target.
- `load_en` in 1: write `load_data` to `load_addr`.
- `load_addr` in ADDR_W: word address for the load.
- `load_data` in 32: instruction word for the load.
- `load_done` in 1: leave LOAD and start fetching at `RESET_PC`.
- `if_instr` out 32: registered instruction.
- `if_pc` out 32: PC of `if_instr`.
- `if_pc_plus4` out 32: `if_pc + 4`, modulo 2^32.
- `if_valid` out 1: `if_*` hold a real instruction.
- `fault` out 1: high while in FAULT.
- `state` out 2: LOAD=0, RUN=1, FAULT=2, for debug.

## Operation
- Reset: `pc`=RESET_PC, state=LOAD, `if_instr`=NOP_WORD, `if_pc`=0, `if_pc_plus4`=0, `if_valid`=0, `fault`=0. Memory contents are not reset.
- LOAD:
  - `load_en` writes memory.
  - `if_valid`=0 and PC is held.
  - `load_done` (with or without `load_en`, whose write is still performed) moves to RUN with `pc`=RESET_PC.
- RUN, per-edge priority:
  1. `load_en`: perform write, go to LOAD, `if_valid`<=0, `pc`<=RESET_PC.
  2. `redirect_en`: if `redirect_pc[1:0]`!=0 or `redirect_pc[31:ADDR_W+2]`!=0, go to FAULT. Otherwise `pc`<=`redirect_pc`. In both cases `if_valid`<=0 and `if_instr`<=NOP_WORD. Redirect overrides `stall`.
  3. `flush`: `if_valid`<=0 and `if_instr`<=NOP_WORD. PC advances unless `stall`.
  4. `stall`: PC and all `if_*` held.
  5. Fetch:
     - If `pc[31:ADDR_W+2]`!=0, go to FAULT and `if_valid`<=0.
     - Otherwise `if_instr`<=mem[`pc[ADDR_W+1:2]`], `if_pc`<=`pc`, `if_pc_plus4`<=`pc`+4, `if_valid`<=1, `pc`<=`pc`+4.
- FAULT:
  - `fault`=1, `if_valid`=0, PC frozen.
  - `stall`, `flush`, `redirect_en` and `load_done` are ignored.
  - `load_en` writes memory and returns to LOAD with `pc`=RESET_PC.
  - Only `load_en` or `rst` leave this state.
- Memory read is combinational on `pc`; write is synchronous. Fetch and write never occur in the same cycle.
- PC arithmetic is 32-bit unsigned, wrapping.

## Timing
- Fetch latency is one cycle: the word at `pc` during cycle k appears on `if_instr` after edge k.
- Steady state gives one instruction per cycle with `if_pc` incrementing by 4.
- Redirect asserted in cycle k gives one bubble after edge k. The target instruction is valid after edge k+1.
- Stall asserted in cycle k: `if_*` after edge k equal those before it.
- `flush` together with `stall`: `if_valid` drops, PC holds.
- Loaded word is readable by the fetch one cycle after its write edge.
- The first valid instruction after `load_done` in cycle k appears after edge k+1.
- `rst` overrides every input. `rst` during LOAD, RUN or FAULT returns to reset values on that edge.
- `fault` rises on the edge that enters FAULT.

## Test plan
- Load words 0x11,0x22,0x33 at addresses 0..2, then `load_done` → `if_instr` sequence 0x11,0x22,0x33 with `if_pc` 0,4,8, `if_valid`=1 on each, `if_pc_plus4` 4,8,12.
- Stall for 3 cycles while `if_pc`=4 → `if_*` held 3 cycles, then 0x33 at `if_pc`=8.
- `redirect_en` with `redirect_pc`=0x0 while `stall`=1 → one cycle `if_valid`=0 with `if_instr`=NOP_WORD, then 0x11 at `if_pc`=0.
- `redirect_pc`=0x6 → `fault`=1, `state`=2, `if_valid`=0. `stall`/`redirect` are then ignored; `load_en` returns to LOAD.
- ADDR_W=5: run sequentially past 0x7C → the fetch at 0x80 enters FAULT and no valid instruction is issued.
- Assert `rst` mid-RUN and hold `load_en` high on the same edge → reset values, memory unchanged, state=LOAD.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: loadable instruction memory, PC with stall/flush/redirect,
// registered IF/ID outputs and a LOAD/RUN/FAULT mode FSM.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  output logic              if_valid,
  output logic              fault,
  output logic [1:0]        state
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned HI_SHIFT = ADDR_W + 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mode_t;

  mode_t       state_q;
  mode_t       state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [31:0] ipc_d;
  logic [31:0] ipc4_d;
  logic        valid_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] fetch_word;
  logic        pc_in_range;
  logic        redirect_ok;

  // Combinational read at the current PC; address bits above the memory are checked separately.
  assign fetch_word  = mem[pc_q[ADDR_W+1:2]];
  assign pc_in_range = (pc_q >> HI_SHIFT) == 32'd0;
  assign redirect_ok = (redirect_pc[1:0] == 2'b00) && ((redirect_pc >> HI_SHIFT) == 32'd0);

  // Next-state and next-output decode with RUN-mode priority load > redirect > flush > stall > fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = if_instr;
    ipc_d   = if_pc;
    ipc4_d  = if_pc_plus4;
    valid_d = if_valid;

    unique case (state_q)
      ST_LOAD: begin
        valid_d = 1'b0;
        if (load_done) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end

      ST_RUN: begin
        if (load_en) begin
          state_d = ST_LOAD;
          valid_d = 1'b0;
          pc_d    = RESET_PC;
        end else if (redirect_en) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
          if (redirect_ok) begin
            pc_d = redirect_pc;
          end else begin
            state_d = ST_FAULT;
          end
        end else if (flush) begin
          valid_d = 1'b0;
          instr_d = NOP_WORD;
          if (!stall) begin
            pc_d = pc_q + 32'd4;
          end
        end else if (!stall) begin
          if (!pc_in_range) begin
            state_d = ST_FAULT;
            valid_d = 1'b0;
          end else begin
            instr_d = fetch_word;
            ipc_d   = pc_q;
            ipc4_d  = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end

      ST_FAULT: begin
        valid_d = 1'b0;
        if (load_en) begin
          state_d = ST_LOAD;
          pc_d    = RESET_PC;
        end
      end

      default: begin
        state_d = ST_FAULT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      pc_q        <= RESET_PC;
      if_instr    <= NOP_WORD;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd0;
      if_valid    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_instr    <= instr_d;
      if_pc       <= ipc_d;
      if_pc_plus4 <= ipc4_d;
      if_valid    <= valid_d;
      fault       <= (state_d == ST_FAULT);
    end
  end

  // Loader writes are accepted in every mode; reset blocks them and never clears contents.
  always_ff @(posedge clk) begin
    if (!rst && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign state = state_q;

endmodule
